// File: rtl/conv_tile_sched_pkg.sv
// ---------------------------------------------------------------------------
// conv_tile_sched_pkg
//   Shared definitions for the convolution tile scheduler:
//   - sched_state_e : scheduler FSM states (IDLE -> RUN -> DRAIN -> IDLE)
//   - clog2         : constant helper used to size the drain counter
// ---------------------------------------------------------------------------
package conv_tile_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(3) = 2 ...
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/conv_tile_sched_loop_idx_cnt.sv
// ---------------------------------------------------------------------------
// loop_idx_cnt
//   Wrapping loop counter 0..MAX-1. Several instances are chained through
//   wrap_o -> inc_i to form a nested loop (innermost first).
// Ports
//   clk_i    clock
//   rst_i    synchronous active-high reset (idx -> 0)
//   inc_i    advance by one this cycle
//   clr_i    synchronous clear, wins over inc_i
//   idx_o    current index (registered)
//   wrap_o   inc_i while idx is MAX-1 (carry into the next outer loop)
// ---------------------------------------------------------------------------
module loop_idx_cnt
  import conv_tile_sched_pkg::*;
#(
  parameter int CW  = 16,
  parameter int MAX = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] idx_o,
  output logic          wrap_o
);

  logic [CW-1:0] idx_q, idx_d;
  logic          at_max;

  assign at_max = (idx_q == CW'(MAX - 1));
  assign wrap_o = inc_i && at_max;
  assign idx_o  = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (clr_i)      idx_d = '0;
    else if (inc_i) idx_d = at_max ? '0 : idx_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) idx_q <= '0;
    else       idx_q <= idx_d;
  end

endmodule

// File: rtl/conv_tile_sched.sv
// ---------------------------------------------------------------------------
// conv_tile_sched
//   Sequences one convolution tile: channel -> kernel row -> kernel col.
//   One MAC iteration is issued per non-stalled RUN cycle together with its
//   indices, a linear weight address and first/last tags. After the final
//   issue the scheduler waits LAT cycles for the datapath to drain, then
//   pulses done.
// Ports
//   clk_i        clock
//   rst_i        synchronous active-high reset (highest priority)
//   start_i      run a tile; honoured only in IDLE
//   abort_i      synchronous kill; back to IDLE without done
//   stall_i      downstream not ready; freezes issue in RUN
//   busy_o       tile in flight (RUN or DRAIN)
//   done_o       one-cycle pulse once the tile has fully drained
//   vld_o        indices/tags below form an issued iteration this cycle
//   ch_idx_o     channel index      0..CH-1
//   kr_idx_o     kernel row index   0..KH-1
//   kc_idx_o     kernel col index   0..KW-1
//   lin_addr_o   ch*KH*KW + kr*KW + kc, kept by an incrementer
//   first_o      with vld_o: iteration 0
//   last_o       with vld_o: iteration CH*KH*KW-1
// ---------------------------------------------------------------------------
module conv_tile_sched
  import conv_tile_sched_pkg::*;
#(
  parameter int CW  = 16,
  parameter int CH  = 16,
  parameter int KH  = 3,
  parameter int KW  = 3,
  parameter int LAT = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          stall_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          vld_o,
  output logic [CW-1:0] ch_idx_o,
  output logic [CW-1:0] kr_idx_o,
  output logic [CW-1:0] kc_idx_o,
  output logic [CW-1:0] lin_addr_o,
  output logic          first_o,
  output logic          last_o
);

  // Drain counter needs to hold LAT-1; keep it at least one bit wide.
  localparam int DW     = (clog2(LAT + 1) < 1) ? 1 : clog2(LAT + 1);
  localparam int LAT_M1 = (LAT > 0) ? LAT - 1 : 0;

  sched_state_e  state_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] lin_addr_q;
  logic [DW-1:0] drain_q;

  logic          issue;
  logic          cnt_clr;
  logic          kc_wrap, kr_wrap, ch_wrap;

  // An iteration goes out on every RUN cycle the datapath can take it.
  assign issue   = (state_q == ST_RUN) && !stall_i;
  // Zero the loop nest on abort and on an accepted start.
  assign cnt_clr = abort_i || ((state_q == ST_IDLE) && start_i);

  // Loop nest, innermost first; each wrap carries into the next level out.
  loop_idx_cnt #(.CW(CW), .MAX(KW)) u_kc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (issue),
    .clr_i  (cnt_clr),
    .idx_o  (kc_idx_o),
    .wrap_o (kc_wrap)
  );

  loop_idx_cnt #(.CW(CW), .MAX(KH)) u_kr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (kc_wrap),
    .clr_i  (cnt_clr),
    .idx_o  (kr_idx_o),
    .wrap_o (kr_wrap)
  );

  loop_idx_cnt #(.CW(CW), .MAX(CH)) u_ch (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (kr_wrap),
    .clr_i  (cnt_clr),
    .idx_o  (ch_idx_o),
    .wrap_o (ch_wrap)
  );

  // The outermost wrap fires exactly on the issue of the final iteration,
  // which saves a separate N-1 comparator.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      lin_addr_q <= '0;
      drain_q    <= '0;
    end else if (abort_i) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      lin_addr_q <= '0;
      drain_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q    <= ST_RUN;
            busy_q     <= 1'b1;
            lin_addr_q <= '0;
          end
        end
        ST_RUN: begin
          if (!stall_i) begin
            if (ch_wrap) begin
              lin_addr_q <= '0;
              if (LAT == 0) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_DRAIN;
                drain_q <= DW'(LAT_M1);
              end
            end else begin
              lin_addr_q <= lin_addr_q + CW'(1);
            end
          end
        end
        ST_DRAIN: begin
          // Counts down LAT-1..0, i.e. LAT cycles spent in DRAIN.
          if (drain_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - DW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign lin_addr_o = lin_addr_q;
  // Stall gates the issue in the same cycle; the indices themselves are
  // registered and simply hold while stalled.
  assign vld_o      = issue;
  assign first_o    = issue && (lin_addr_q == '0);
  assign last_o     = ch_wrap;

endmodule

// File: tb/tb_conv_tile_sched.sv
module tb_conv_tile_sched;
  localparam int CW = 16;
  localparam int P_CH  [2] = '{2, 1};
  localparam int P_KH  [2] = '{3, 1};
  localparam int P_KW  [2] = '{3, 1};
  localparam int P_LAT [2] = '{2, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, abort = 1'b0, stall = 1'b0;
  logic          busy_o [2], done_o [2], vld_o [2], first_o [2], last_o [2];
  logic [CW-1:0] ch_o [2], kr_o [2], kc_o [2], addr_o [2];

  conv_tile_sched #(.CW(CW), .CH(2), .KH(3), .KW(3), .LAT(2)) u_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .stall_i(stall),
    .busy_o(busy_o[0]), .done_o(done_o[0]), .vld_o(vld_o[0]),
    .ch_idx_o(ch_o[0]), .kr_idx_o(kr_o[0]), .kc_idx_o(kc_o[0]),
    .lin_addr_o(addr_o[0]), .first_o(first_o[0]), .last_o(last_o[0]));

  conv_tile_sched #(.CW(CW), .CH(1), .KH(1), .KW(1), .LAT(0)) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .stall_i(stall),
    .busy_o(busy_o[1]), .done_o(done_o[1]), .vld_o(vld_o[1]),
    .ch_idx_o(ch_o[1]), .kr_idx_o(kr_o[1]), .kc_idx_o(kc_o[1]),
    .lin_addr_o(addr_o[1]), .first_o(first_o[1]), .last_o(last_o[1]));

  // Reference model: per tile, how many iterations have gone out and how
  // many cycles have elapsed since the final one.
  bit m_act [2];
  int m_k [2];
  int m_tail [2];
  bit m_done [2];

  int n_pass = 0, n_total = 0;
  int cyc = 0;
  int done_cyc [2];
  int done_cnt [2];
  int vld_cnt [2];
  int t0, t1;

  task automatic check(input string tag, input int d, input logic [CW-1:0] got,
                       input logic [CW-1:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s dut%0d cycle %0d: got %0d expected %0d", tag, d, cyc, got, exp);
  endtask

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      done_cyc[d] = -1;
      done_cnt[d] = 0;
      vld_cnt[d]  = 0;
    end
  endtask

  // One clock cycle: apply inputs after the falling edge, check outputs,
  // then advance the model with the inputs seen at the rising edge.
  task automatic step(input bit s = 1'b0, input bit st = 1'b0,
                      input bit ab = 1'b0, input bit r = 1'b0);
    start = s; stall = st; abort = ab; rst = r;
    #1;
    for (int d = 0; d < 2; d++) begin
      int n, k, e_ch, e_kr, e_kc, e_addr;
      bit e_vld;
      n = P_CH[d] * P_KH[d] * P_KW[d];
      k = m_k[d];
      e_vld = m_act[d] && (k < n) && !st;
      if (m_act[d] && k < n) begin
        e_ch   = k / (P_KH[d] * P_KW[d]);
        e_kr   = (k / P_KW[d]) % P_KH[d];
        e_kc   = k % P_KW[d];
        e_addr = k;
      end else begin
        e_ch = 0; e_kr = 0; e_kc = 0; e_addr = 0;
      end
      check("busy",  d, CW'(busy_o[d]),  CW'(m_act[d]));
      check("done",  d, CW'(done_o[d]),  CW'(m_done[d]));
      check("vld",   d, CW'(vld_o[d]),   CW'(e_vld));
      check("first", d, CW'(first_o[d]), CW'(e_vld && k == 0));
      check("last",  d, CW'(last_o[d]),  CW'(e_vld && k == n - 1));
      check("ch",    d, ch_o[d],   CW'(e_ch));
      check("kr",    d, kr_o[d],   CW'(e_kr));
      check("kc",    d, kc_o[d],   CW'(e_kc));
      check("addr",  d, addr_o[d], CW'(e_addr));
      if (done_o[d] === 1'b1) begin
        done_cnt[d]++;
        if (done_cyc[d] < 0) done_cyc[d] = cyc;
      end
      if (vld_o[d] === 1'b1) vld_cnt[d]++;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      int n;
      n = P_CH[d] * P_KH[d] * P_KW[d];
      if (r || ab) begin
        m_act[d] = 1'b0; m_k[d] = 0; m_tail[d] = 0; m_done[d] = 1'b0;
      end else begin
        m_done[d] = 1'b0;
        if (!m_act[d]) begin
          if (s) begin m_act[d] = 1'b1; m_k[d] = 0; m_tail[d] = 0; end
        end else if (m_k[d] < n) begin
          if (!st) begin
            m_k[d]++;
            if (m_k[d] == n && P_LAT[d] == 0) begin m_act[d] = 1'b0; m_done[d] = 1'b1; end
          end
        end else begin
          m_tail[d]++;
          if (m_tail[d] == P_LAT[d]) begin m_act[d] = 1'b0; m_done[d] = 1'b1; end
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0; m_k[d] = 0; m_tail[d] = 0; m_done[d] = 1'b0;
    end
    clear_stats();
    @(negedge clk);
    // Reset state
    step(0, 0, 0, 1);
    step();

    // Full tile without stalls (and the 1x1x1 LAT=0 tile on the second DUT)
    clear_stats(); t0 = cyc;
    step(1);
    repeat (25) step();
    check("t1_done_at", 0, CW'(done_cyc[0] - t0), CW'(21));
    check("t1_issues",  0, CW'(vld_cnt[0]), CW'(18));
    check("t5_done_at", 1, CW'(done_cyc[1] - t0), CW'(2));
    check("t5_issues",  1, CW'(vld_cnt[1]), CW'(1));

    // Three stalled cycles at the 5th issue
    clear_stats(); t0 = cyc;
    step(1);
    repeat (4) step();
    repeat (3) begin
      check("t2_hold_kr",   0, kr_o[0], CW'(1));
      check("t2_hold_addr", 0, addr_o[0], CW'(4));
      step(0, 1);
    end
    repeat (25) step();
    check("t2_done_at", 0, CW'(done_cyc[0] - t0), CW'(24));
    check("t2_issues",  0, CW'(vld_cnt[0]), CW'(18));

    // Abort at the 10th issue, then a fresh full run
    clear_stats(); t0 = cyc;
    step(1);
    repeat (9) step();
    step(0, 0, 1);
    repeat (5) step();
    check("t3_no_done", 0, CW'(done_cnt[0]), CW'(0));
    clear_stats(); t0 = cyc;
    step(1);
    repeat (25) step();
    check("t3_rerun_issues", 0, CW'(vld_cnt[0]), CW'(18));
    check("t3_rerun_done",   0, CW'(done_cyc[0] - t0), CW'(21));

    // Random starts while busy, then start in the done cycle
    clear_stats(); t0 = cyc;
    step(1);
    repeat (20) step(1'($urandom_range(0, 1)));
    check("t4_in_done_cycle", 0, CW'(done_o[0]), CW'(1));
    t1 = cyc;
    step(1);
    check("t4_first_dc", 0, CW'(done_cyc[0] - t0), CW'(21));
    check("t4_issues_1", 0, CW'(vld_cnt[0]), CW'(18));
    clear_stats();
    repeat (25) step();
    check("t4_issues_2", 0, CW'(vld_cnt[0]), CW'(18));
    check("t4_done_2",   0, CW'(done_cyc[0] - t1), CW'(21));

    // Reset mid-RUN and mid-DRAIN
    clear_stats();
    step(1);
    repeat (5) step();
    step(0, 0, 0, 1);
    step(1);
    repeat (18) step();
    step(0, 0, 0, 1);
    repeat (5) step();
    check("t6_no_done", 0, CW'(done_cnt[0]), CW'(0));

    // Randomised traffic against the model
    repeat (600) step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 127) == 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
